// File: rtl/cache_param_pkg.sv
// Shared cache parameters and the lookup request payload used on the cache_pipe lookup port.
package cache_param_pkg;

  localparam int unsigned SET_ADRS_WIDTH = 6;
  localparam int unsigned OFFSET_WIDTH   = 6;
  localparam int unsigned TAG_WIDTH      = 20;
  localparam int unsigned ADRS_WIDTH     = TAG_WIDTH + SET_ADRS_WIDTH + OFFSET_WIDTH;
  localparam int unsigned DATA_WIDTH     = 32;
  localparam int unsigned RD_INDX_WIDTH  = 4;
  localparam int unsigned STARVE_WIDTH   = 4;

  typedef enum logic [2:0] {
    NOP_OP  = 3'd0,
    RD_OP   = 3'd1,
    WR_OP   = 3'd2,
    FILL_OP = 3'd3,
    INIT_OP = 3'd4
  } t_lu_op;

  typedef struct packed {
    logic                     valid;
    t_lu_op                   lu_op;
    logic [ADRS_WIDTH-1:0]    address;
    logic [DATA_WIDTH-1:0]    data;
    logic [RD_INDX_WIDTH-1:0] rd_indx;
  } t_lu_req;

  // A granted request always enters the pipe marked valid, whatever the requester drove.
  function automatic t_lu_req mark_valid(input t_lu_req req);
    t_lu_req r;
    r       = req;
    r.valid = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/cache_lu_arb_if.sv
// Requester/pipe side bundle of the lookup arbiter.
interface cache_lu_arb_if;
  import cache_param_pkg::*;

  logic    core_req_valid;
  t_lu_req core_req;
  logic    core_req_ready;
  logic    fill_req_valid;
  t_lu_req fill_req;
  logic    fill_req_ready;
  logic    pipe_stall;
  t_lu_req pipe_lu_req_q1;
  logic    init_done;

  modport master (
    output core_req_valid, core_req, fill_req_valid, fill_req, pipe_stall,
    input  core_req_ready, fill_req_ready, pipe_lu_req_q1, init_done
  );

  modport slave (
    input  core_req_valid, core_req, fill_req_valid, fill_req, pipe_stall,
    output core_req_ready, fill_req_ready, pipe_lu_req_q1, init_done
  );

endinterface

// File: rtl/cache_init_seq.sv
// Set counter for the post-reset tag invalidation sweep; emits one INIT_OP lookup per advance.
module cache_init_seq
  import cache_param_pkg::*;
#(
  parameter int unsigned SET_ADRS_WIDTH = cache_param_pkg::SET_ADRS_WIDTH
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    adv,
  output t_lu_req init_req_c,
  output logic    sweep_last_c
);

  localparam int unsigned PKG_SET_WIDTH = cache_param_pkg::SET_ADRS_WIDTH;

  logic [SET_ADRS_WIDTH-1:0] set_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      set_cnt <= '0;
    end else if (adv) begin
      set_cnt <= set_cnt + SET_ADRS_WIDTH'(1);
    end
  end

  always_comb begin
    init_req_c         = '0;
    init_req_c.valid   = 1'b1;
    init_req_c.lu_op   = INIT_OP;
    init_req_c.address = {TAG_WIDTH'(0), PKG_SET_WIDTH'(set_cnt), OFFSET_WIDTH'(0)};
    sweep_last_c       = (set_cnt == '1);
  end

endmodule

// File: rtl/cache_lu_arb.sv
// Lookup slot arbiter in front of cache_pipe: invalidation sweep after reset, then
// fill-priority arbitration with a starvation guard for core requests.
module cache_lu_arb
  import cache_param_pkg::*;
#(
  parameter int unsigned SET_ADRS_WIDTH = cache_param_pkg::SET_ADRS_WIDTH,
  parameter int unsigned STARVE_LIMIT   = 4
) (
  input logic           clk,
  input logic           rst,
  cache_lu_arb_if.slave lu
);

  typedef enum logic {INIT, RUN} t_arb_state;

  t_arb_state              state;
  logic [STARVE_WIDTH-1:0] starve_cnt;
  logic                    starve_hit;
  logic                    slot_open;
  logic                    core_win;
  logic                    fill_win;
  logic                    issue_init;
  t_lu_req                 init_req;
  logic                    sweep_last;

  cache_init_seq #(
    .SET_ADRS_WIDTH (SET_ADRS_WIDTH)
  ) u_init_seq (
    .clk          (clk),
    .rst          (rst),
    .adv          (issue_init),
    .init_req_c   (init_req),
    .sweep_last_c (sweep_last)
  );

  // Grant decision; readies are combinational so a requester sees acceptance in the same cycle.
  always_comb begin
    issue_init        = (state == INIT) && !lu.pipe_stall;
    slot_open         = (state == RUN) && !lu.pipe_stall;
    starve_hit        = (starve_cnt == STARVE_WIDTH'(STARVE_LIMIT));
    core_win          = slot_open && lu.core_req_valid && (!lu.fill_req_valid || starve_hit);
    fill_win          = slot_open && lu.fill_req_valid && !core_win;
    lu.core_req_ready = core_win;
    lu.fill_req_ready = fill_win;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= INIT;
      starve_cnt        <= '0;
      lu.pipe_lu_req_q1 <= '0;
      lu.init_done      <= 1'b0;
    end else begin
      lu.pipe_lu_req_q1 <= '0;
      case (state)
        INIT: begin
          if (issue_init) begin
            lu.pipe_lu_req_q1 <= init_req;
            if (sweep_last) begin
              state        <= RUN;
              lu.init_done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (core_win) begin
            lu.pipe_lu_req_q1 <= mark_valid(lu.core_req);
          end else if (fill_win) begin
            lu.pipe_lu_req_q1 <= mark_valid(lu.fill_req);
          end
        end
        default: begin
          state <= INIT;
        end
      endcase

      // Counts fill grants that overtook a waiting core request.
      if (!lu.core_req_valid || core_win) begin
        starve_cnt <= '0;
      end else if (fill_win && !starve_hit) begin
        starve_cnt <= starve_cnt + STARVE_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_cache_lu_arb.sv
// Directed bench for cache_lu_arb with SET_ADRS_WIDTH=2 and STARVE_LIMIT=2.
module tb_cache_lu_arb;
  import cache_param_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  cache_lu_arb_if bus ();

  cache_lu_arb #(
    .SET_ADRS_WIDTH (2),
    .STARVE_LIMIT   (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .lu  (bus)
  );

  function automatic t_lu_req mk(input logic v, input t_lu_op op, input logic [31:0] adr,
                                 input logic [31:0] dat, input logic [3:0] ix);
    t_lu_req r;
    r         = '0;
    r.valid   = v;
    r.lu_op   = op;
    r.address = adr;
    r.data    = dat;
    r.rd_indx = ix;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Checks the sweep lookup presented this cycle, then advances one clock.
  task automatic sweep_cycle(input int set, input logic done);
    @(negedge clk);
    chk($sformatf("sweep_q1_set%0d", set), 128'(bus.pipe_lu_req_q1),
        128'(mk(1'b1, INIT_OP, 32'(set) << 6, 32'h0, 4'h0)));
    chk($sformatf("sweep_done_set%0d", set), 128'(bus.init_done), 128'(done));
    chk($sformatf("sweep_rdy_set%0d", set), 128'({bus.core_req_ready, bus.fill_req_ready}), 128'(2'b00));
    next_cycle();
  endtask

  t_lu_req core_rd, core_wr, fill_a;
  logic [5:0] fill_first;

  initial begin
    core_rd    = mk(1'b0, RD_OP,   32'h0000_0040, 32'h0000_1234, 4'h3);
    core_wr    = mk(1'b0, WR_OP,   32'h0000_00C0, 32'h0000_C0DE, 4'h2);
    fill_a     = mk(1'b0, FILL_OP, 32'h0000_0080, 32'h0000_0F11, 4'h1);
    fill_first = 6'b011011;  // bit i = expected winner of cycle i is fill (LSB first)

    rst                = 1'b1;
    bus.pipe_stall     = 1'b0;
    bus.core_req_valid = 1'b0;
    bus.fill_req_valid = 1'b0;
    bus.core_req       = '0;
    bus.fill_req       = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_q1",   128'(bus.pipe_lu_req_q1), 128'(0));
    chk("rst_done", 128'(bus.init_done), 128'(0));
    chk("rst_rdy",  128'({bus.core_req_ready, bus.fill_req_ready}), 128'(2'b00));
    rst = 1'b0;
    next_cycle();

    sweep_cycle(0, 1'b0);
    sweep_cycle(1, 1'b0);
    sweep_cycle(2, 1'b0);

    // Set 3 cycle: RUN is already active, so a core request is granted here.
    bus.core_req_valid = 1'b1;
    bus.core_req       = core_rd;
    @(negedge clk);
    chk("last_sweep_q1", 128'(bus.pipe_lu_req_q1), 128'(mk(1'b1, INIT_OP, 32'hC0, 32'h0, 4'h0)));
    chk("last_sweep_done", 128'(bus.init_done), 128'(1));
    chk("core_single_rdy", 128'({bus.core_req_ready, bus.fill_req_ready}), 128'(2'b10));
    next_cycle();
    bus.core_req_valid = 1'b0;
    @(negedge clk);
    chk("core_single_q1", 128'(bus.pipe_lu_req_q1), 128'(mk(1'b1, RD_OP, 32'h40, 32'h1234, 4'h3)));
    next_cycle();
    @(negedge clk);
    chk("core_single_idle", 128'(bus.pipe_lu_req_q1), 128'(0));
    next_cycle();

    // Both requesters continuously valid: F F C F F C.
    bus.core_req_valid = 1'b1;
    bus.core_req       = core_wr;
    bus.fill_req_valid = 1'b1;
    bus.fill_req       = fill_a;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("starve_rdy_%0d", i), 128'({bus.core_req_ready, bus.fill_req_ready}),
          128'(fill_first[i] ? 2'b01 : 2'b10));
      if (i > 0)
        chk($sformatf("starve_q1_%0d", i), 128'(bus.pipe_lu_req_q1),
            fill_first[i-1] ? 128'(mk(1'b1, FILL_OP, 32'h80, 32'hF11, 4'h1))
                            : 128'(mk(1'b1, WR_OP, 32'hC0, 32'hC0DE, 4'h2)));
      next_cycle();
    end

    // Stall in RUN with both valid.
    bus.pipe_stall = 1'b1;
    @(negedge clk);
    chk("starve_q1_5", 128'(bus.pipe_lu_req_q1), 128'(mk(1'b1, WR_OP, 32'hC0, 32'hC0DE, 4'h2)));
    chk("stall_rdy_0", 128'({bus.core_req_ready, bus.fill_req_ready}), 128'(2'b00));
    next_cycle();
    @(negedge clk);
    chk("stall_q1_0",  128'(bus.pipe_lu_req_q1), 128'(0));
    chk("stall_rdy_1", 128'({bus.core_req_ready, bus.fill_req_ready}), 128'(2'b00));
    next_cycle();
    bus.pipe_stall = 1'b0;
    @(negedge clk);
    chk("stall_q1_1",      128'(bus.pipe_lu_req_q1), 128'(0));
    chk("unstall_rdy",     128'({bus.core_req_ready, bus.fill_req_ready}), 128'(2'b01));
    next_cycle();
    @(negedge clk);
    chk("unstall_q1",      128'(bus.pipe_lu_req_q1), 128'(mk(1'b1, FILL_OP, 32'h80, 32'hF11, 4'h1)));
    chk("pre_rst_rdy",     128'({bus.core_req_ready, bus.fill_req_ready}), 128'(2'b01));

    // Asynchronous reset with a grant in flight.
    rst = 1'b1;
    #1;
    chk("midrst_q1",   128'(bus.pipe_lu_req_q1), 128'(0));
    chk("midrst_done", 128'(bus.init_done), 128'(0));
    chk("midrst_rdy",  128'({bus.core_req_ready, bus.fill_req_ready}), 128'(2'b00));
    bus.core_req_valid = 1'b0;
    bus.fill_req_valid = 1'b0;
    next_cycle();
    rst = 1'b0;
    next_cycle();

    // Sweep again, stalled for 3 cycles after set 1.
    sweep_cycle(0, 1'b0);
    bus.pipe_stall = 1'b1;
    sweep_cycle(1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) bus.pipe_stall = 1'b0;
      @(negedge clk);
      chk($sformatf("init_stall_q1_%0d", i), 128'(bus.pipe_lu_req_q1), 128'(0));
      chk($sformatf("init_stall_done_%0d", i), 128'(bus.init_done), 128'(0));
      next_cycle();
    end
    sweep_cycle(2, 1'b0);
    sweep_cycle(3, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cache_lu_arb.md
# cache_lu_arb

Lookup-request arbiter and sequencer sitting directly in front of `cache_pipe`'s `pipe_lu_req_q1` input. It runs a post-reset tag-array invalidation sweep, then shares the single lookup slot between two requesters:
- FM fill returns (priority)
- core/TQ requests (starvation-protected)

It drives one registered lookup per cycle into the pipe.

## Interface
Parameters:
- `SET_ADRS_WIDTH`, default `cache_param_pkg::SET_ADRS_WIDTH`: set-index width; sweep covers 2^SET_ADRS_WIDTH sets.
- `STARVE_LIMIT`, default 4: maximum consecutive fill grants while a core request waits (range 1..15).

Ports (clock and reset: one clock; reset is asynchronous and active-high):
- `clk`  in  1  clock.
- `rst`  in  1  reset.
- `core_req_valid`  in  1  core request present.
- `core_req`  in  `t_lu_req`  core lookup (RD_OP/WR_OP).
- `core_req_ready`  out  1  core request accepted this cycle.
- `fill_req_valid`  in  1  fill present.
- `fill_req`  in  `t_lu_req`  fill lookup (FILL_OP).
- `fill_req_ready`  out  1  fill accepted this cycle.
- `pipe_stall`  in  1  downstream (TQ/FM) cannot take new lookups; no grant, no sweep advance.
- `pipe_lu_req_q1`  out  `t_lu_req`  registered lookup to cache_pipe; `.valid` qualifies it.
- `init_done`  out  1  sweep complete, arbitration enabled.

## Operation
- FSM has two states, INIT and RUN. Reset enters INIT with set counter `set_cnt`=0.
- **INIT**
  - Each cycle with `pipe_stall`=0, issue a lookup with `lu_op`=INIT_OP and `address` = {tag=0, set=`set_cnt`, offset=0}; then increment `set_cnt`.
  - After issuing set 2^SET_ADRS_WIDTH-1, go to RUN. No wrap occurs; the counter is unused in RUN.
  - Both readies are held 0.
- **RUN**
  - Readies are combinational; at most one is high per cycle, and none while `pipe_stall`=1.
  - Default priority: fill over core.
  - Starvation counter `starve_cnt` (4 bits, saturating at STARVE_LIMIT):
    - increments on each fill grant while `core_req_valid`=1;
    - clears on a core grant or whenever `core_req_valid`=0.
  - When `starve_cnt`==STARVE_LIMIT and `core_req_valid`=1, core wins over a valid fill.
  - A grant (valid&ready) registers the winner's request into `pipe_lu_req_q1` with `.valid`=1. Cycles with no grant register `.valid`=0 and the other fields as zero.
- Requesters must hold valid and request stable until ready. The block does not buffer unaccepted requests.
- `init_done`=1 exactly in RUN.

## Timing
- Reset values:
  - `pipe_lu_req_q1` = all zeros;
  - `core_req_ready`=0, `fill_req_ready`=0, `init_done`=0;
  - state INIT, `set_cnt`=0, `starve_cnt`=0.
- Latency: grant at edge N → `pipe_lu_req_q1` valid for exactly the cycle after edge N (1 cycle).
- Sweep:
  - first INIT_OP appears the cycle after reset deassertion (given no stall);
  - the last sweep lookup and the `init_done` rise occur in the same cycle;
  - the first RUN grant can be made in that cycle.
- `pipe_stall`=1 in RUN: readies are 0 combinationally in that cycle, and the next `pipe_lu_req_q1.valid`=0. In INIT, `set_cnt` holds.
- Simultaneous fill and core, `starve_cnt`<STARVE_LIMIT: fill granted. At the limit: core granted, and the counter clears next edge.
- `rst` asserted mid-operation: all state and outputs clear asynchronously, any in-flight grant is lost, and the full sweep restarts.

## Structure
- `cache_param_pkg` holds:
  - `t_lu_req` (valid, lu_op, address, data, rd_indx);
  - `t_lu_op` enum, including INIT_OP;
  - `SET_ADRS_WIDTH`, `OFFSET_WIDTH`, `TAG_WIDTH`.
- Arbiter state enum `t_arb_state` {INIT, RUN} is local.
- Natural sub-module: `cache_init_seq`. It holds the set counter and produces INIT_OP requests plus a `sweep_last` flag. The top does arbitration and the output register.

## Test plan
Bench uses SET_ADRS_WIDTH=2, STARVE_LIMIT=2.
- Reset release, no stall: INIT_OP to sets 0,1,2,3 on 4 consecutive cycles. `init_done`=1 in the cycle set 3 is presented. Readies stay 0 throughout.
- Stall in INIT: `pipe_stall`=1 for 3 cycles after set 1 → set 2 appears 3 cycles late. No set is skipped or duplicated.
- RUN, single core RD_OP address 0x40 → `core_req_ready`=1 same cycle; next cycle `pipe_lu_req_q1`={valid=1, RD_OP, 0x40}, then valid=0.
- Fill and core both valid continuously → grant order: fill, fill, core, fill, fill, core …; the core request is never waiting more than 3 cycles.
- RUN with `pipe_stall`=1 and both valid → both readies 0, `pipe_lu_req_q1.valid`=0. After stall drops, fill is granted first.
- `rst` pulsed while in RUN with grants in flight → outputs zero immediately, `init_done`=0, and the sweep re-runs from set 0.
